// File: rtl/spi_slave.sv
// SPI mode-0 target with oversampled inputs, double-buffered transmit and single receive register.
// Optional macro SPIS_IRQ_EN adds a registered irq output.
module spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        word,
    input  logic [31:0] dataTx,
    input  logic        txLoad,
    output logic        txEmpty,
    output logic [31:0] dataRx,
    output logic        rxFull,
    input  logic        rdRx,
    output logic        ovr,
    input  logic        SCLK,
    input  logic        SS,
    input  logic        MOSI,
    output logic        MISO,
`ifdef SPIS_IRQ_EN
    output logic        irq,
`endif
    output logic        misoOe
);

    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [1:0] {IDLE, ACTIVE, WAITHI} state_t;

    logic [STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
    logic              sclk_s, ss_s, mosi_s;
    logic              sclk_prev, sclk_rise, sclk_fall;
    logic              load_d, read_d, load_strobe, read_strobe;
    state_t            state;
    logic              wide, complete, start_frame;
    logic [5:0]        bitcnt, frame_len;
    logic [31:0]       tx_hold, tx_shift, tx_next, rx_shift;

    // Wire bit k carries data bit 8*(k/8) + 7 - (k%8): byte index kept, bit order reversed.
    function automatic logic [4:0] wire_pos(input logic [4:0] k);
        return {k[4:3], ~k[2:0]};
    endfunction

    // Synchronizers reset to "selected" so WAITHI only leaves on a genuinely high SS.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            ss_sync   <= '0;
            mosi_sync <= '0;
        end else begin
            sclk_sync <= {sclk_sync[STAGES-2:0], SCLK};
            ss_sync   <= {ss_sync[STAGES-2:0], SS};
            mosi_sync <= {mosi_sync[STAGES-2:0], MOSI};
        end
    end

    assign sclk_s      = sclk_sync[STAGES-1];
    assign ss_s        = ss_sync[STAGES-1];
    assign mosi_s      = mosi_sync[STAGES-1];
    assign sclk_rise   = sclk_s & ~sclk_prev;
    assign sclk_fall   = ~sclk_s & sclk_prev;
    assign load_strobe = txLoad & ~load_d;
    assign read_strobe = rdRx & ~read_d;
    assign frame_len   = wide ? 6'd32 : 6'd8;
    assign tx_next     = txEmpty ? 32'hFFFF_FFFF : tx_hold;
    assign start_frame = ~ss_s & ((state == IDLE) ||
                         ((state == ACTIVE) && sclk_fall && (bitcnt == frame_len)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= WAITHI;
            sclk_prev <= 1'b0;
            load_d    <= 1'b0;
            read_d    <= 1'b0;
            wide      <= 1'b0;
            complete  <= 1'b0;
            bitcnt    <= '0;
            tx_hold   <= '0;
            tx_shift  <= '0;
            rx_shift  <= '0;
            txEmpty   <= 1'b1;
            dataRx    <= '0;
            rxFull    <= 1'b0;
            ovr       <= 1'b0;
            MISO      <= 1'b1;
            misoOe    <= 1'b0;
        end else begin
            sclk_prev <= sclk_s;
            load_d    <= txLoad;
            read_d    <= rdRx;
            complete  <= 1'b0;

            case (state)
                WAITHI: if (ss_s) state <= IDLE;
                ACTIVE: begin
                    if (ss_s) begin
                        state  <= IDLE;
                        MISO   <= 1'b1;
                        misoOe <= 1'b0;
                    end else if (sclk_rise && bitcnt < frame_len) begin
                        rx_shift[wire_pos(bitcnt[4:0])] <= mosi_s;
                        bitcnt <= bitcnt + 6'd1;
                        if (bitcnt == frame_len - 6'd1) complete <= 1'b1;
                    end else if (sclk_fall && bitcnt < frame_len) begin
                        MISO <= tx_shift[wire_pos(bitcnt[4:0])];
                    end
                end
                default: ;
            endcase

            // A fresh frame takes the old holding contents; a same-cycle load refills it below.
            if (start_frame) begin
                state    <= ACTIVE;
                wide     <= word;
                tx_shift <= tx_next;
                txEmpty  <= 1'b1;
                bitcnt   <= '0;
                MISO     <= tx_next[7];
                misoOe   <= 1'b1;
            end

            if (load_strobe) begin
                tx_hold <= dataTx;
                txEmpty <= 1'b0;
            end

            // Completion beats a simultaneous read so the new frame is never silently lost.
            if (complete) begin
                dataRx <= wide ? rx_shift : {24'd0, rx_shift[7:0]};
                rxFull <= 1'b1;
                if (rxFull) ovr <= 1'b1;
            end else if (read_strobe) begin
                rxFull <= 1'b0;
                ovr    <= 1'b0;
            end
        end
    end

`ifdef SPIS_IRQ_EN
    always_ff @(posedge clk) begin
        if (rst) irq <= 1'b0;
        else     irq <= rxFull | ovr | (txEmpty & misoOe);
    end
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: vector table, hand-written corner sequences and randomized frames.
module tb_spi_slave;

    logic        clk = 1'b0;
    logic        rst, word, txLoad, rdRx, SCLK, SS, MOSI;
    logic [31:0] dataTx, dataRx;
    logic        txEmpty, rxFull, ovr, MISO, misoOe;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spi_slave #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .word(word), .dataTx(dataTx), .txLoad(txLoad),
        .txEmpty(txEmpty), .dataRx(dataRx), .rxFull(rxFull), .rdRx(rdRx), .ovr(ovr),
        .SCLK(SCLK), .SS(SS), .MOSI(MOSI), .MISO(MISO), .misoOe(misoOe)
    );

    typedef struct {
        bit          w;
        bit          doRead;
        bit          doLoad;
        logic [31:0] tx;
        logic [31:0] mosi;
        logic [31:0] expMiso;
        logic [31:0] expRx;
        bit          expFull;
        bit          expOvr;
    } vec_t;

    vec_t        vecs[4];
    logic [31:0] misoVal, mask, expTx, holdVal, mRx, rv;
    bit          holdValid, mFull, mOvr, rw;

    function automatic int wireIdx(input int k);
        return 8 * (k / 8) + 7 - (k % 8);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulseLoad(input logic [31:0] v);
        dataTx = v;
        txLoad = 1'b1;
        waitClk(1);
        txLoad = 1'b0;
        waitClk(1);
    endtask

    task automatic pulseRead();
        rdRx = 1'b1;
        waitClk(1);
        rdRx = 1'b0;
        waitClk(1);
    endtask

    // Master side: mode 0, each SCLK phase 4 clk; optionally ends the frame by raising SS while SCLK is high.
    task automatic shiftBits(input int n, input logic [31:0] mosiBits, input bit endFrame,
                             output logic [31:0] misoBits);
        misoBits = '0;
        for (int k = 0; k < n; k++) begin
            MOSI = mosiBits[wireIdx(k)];
            waitClk(1);
            misoBits[wireIdx(k)] = MISO;
            SCLK = 1'b1;
            waitClk(4);
            if (endFrame && k == n - 1) begin
                SS = 1'b1;
                waitClk(4);
            end
            SCLK = 1'b0;
            waitClk(3);
        end
        if (endFrame) waitClk(4);
    endtask

    task automatic applyStimulus(input bit w, input logic [31:0] mosiBits, output logic [31:0] misoBits);
        word = w;
        SS   = 1'b0;
        waitClk(4);
        shiftBits(w ? 32 : 8, mosiBits, 1'b1, misoBits);
    endtask

    initial begin
        rst = 1'b1; word = 1'b0; txLoad = 1'b0; rdRx = 1'b0;
        SCLK = 1'b0; SS = 1'b1; MOSI = 1'b0; dataTx = '0;

        vecs[0] = '{1'b0, 1'b0, 1'b1, 32'h0000_00A5, 32'h0000_003C, 32'h0000_00A5, 32'h0000_003C, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h1234_5678, 32'hCAFE_BABE, 32'h1234_5678, 32'hCAFE_BABE, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0081, 32'h0000_00FF, 32'h0000_0081, 1'b1, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_00FF, 32'h0000_0000, 32'h0000_00FF, 1'b1, 1'b0};

        waitClk(3);
        checkOutput("reset txEmpty", {31'd0, txEmpty}, 32'd1);
        checkOutput("reset rxFull", {31'd0, rxFull}, 32'd0);
        checkOutput("reset ovr", {31'd0, ovr}, 32'd0);
        checkOutput("reset dataRx", dataRx, 32'd0);
        checkOutput("reset MISO", {31'd0, MISO}, 32'd1);
        checkOutput("reset misoOe", {31'd0, misoOe}, 32'd0);
        rst = 1'b0;
        waitClk(6);

        foreach (vecs[i]) begin
            if (vecs[i].doRead) pulseRead();
            if (vecs[i].doLoad) pulseLoad(vecs[i].tx);
            mask = vecs[i].w ? 32'hFFFF_FFFF : 32'h0000_00FF;
            applyStimulus(vecs[i].w, vecs[i].mosi, misoVal);
            checkOutput($sformatf("vec%0d miso", i), misoVal & mask, vecs[i].expMiso);
            checkOutput($sformatf("vec%0d dataRx", i), dataRx, vecs[i].expRx);
            checkOutput($sformatf("vec%0d rxFull", i), {31'd0, rxFull}, {31'd0, vecs[i].expFull});
            checkOutput($sformatf("vec%0d ovr", i), {31'd0, ovr}, {31'd0, vecs[i].expOvr});
            checkOutput($sformatf("vec%0d txEmpty", i), {31'd0, txEmpty}, 32'd1);
            checkOutput($sformatf("vec%0d misoOe idle", i), {31'd0, misoOe}, 32'd0);
        end

        // Two bytes under one SS with no read in between: second byte underruns and overruns.
        pulseRead();
        pulseLoad(32'h0000_003A);
        word = 1'b0;
        SS   = 1'b0;
        waitClk(4);
        shiftBits(16, 32'h0000_C35A, 1'b1, misoVal);
        checkOutput("b2b miso", misoVal, 32'h0000_FF3A);
        checkOutput("b2b dataRx", dataRx, 32'h0000_00C3);
        checkOutput("b2b rxFull", {31'd0, rxFull}, 32'd1);
        checkOutput("b2b ovr", {31'd0, ovr}, 32'd1);
        pulseRead();
        checkOutput("b2b read rxFull", {31'd0, rxFull}, 32'd0);
        checkOutput("b2b read ovr", {31'd0, ovr}, 32'd0);

        // SS raised after 5 bits discards the partial byte.
        SS = 1'b0;
        waitClk(4);
        shiftBits(5, 32'h0000_00F0, 1'b0, misoVal);
        SS = 1'b1;
        waitClk(8);
        checkOutput("abort rxFull", {31'd0, rxFull}, 32'd0);
        checkOutput("abort dataRx", dataRx, 32'h0000_00C3);
        checkOutput("abort misoOe", {31'd0, misoOe}, 32'd0);
        applyStimulus(1'b0, 32'h0000_0067, misoVal);
        checkOutput("after abort dataRx", dataRx, 32'h0000_0067);
        checkOutput("after abort rxFull", {31'd0, rxFull}, 32'd1);

        // Reset mid-frame while SS stays low: nothing received until SS cycles high then low.
        SS = 1'b0;
        waitClk(4);
        shiftBits(3, 32'h0000_00AA, 1'b0, misoVal);
        rst = 1'b1;
        waitClk(1);
        rst = 1'b0;
        waitClk(1);
        checkOutput("rst MISO", {31'd0, MISO}, 32'd1);
        checkOutput("rst misoOe", {31'd0, misoOe}, 32'd0);
        checkOutput("rst rxFull", {31'd0, rxFull}, 32'd0);
        checkOutput("rst dataRx", dataRx, 32'd0);
        shiftBits(8, 32'h0000_0055, 1'b0, misoVal);
        checkOutput("waithi rxFull", {31'd0, rxFull}, 32'd0);
        checkOutput("waithi misoOe", {31'd0, misoOe}, 32'd0);
        SS = 1'b1;
        waitClk(6);
        applyStimulus(1'b0, 32'h0000_0096, misoVal);
        checkOutput("post rst miso", misoVal, 32'h0000_00FF);
        checkOutput("post rst dataRx", dataRx, 32'h0000_0096);
        checkOutput("post rst rxFull", {31'd0, rxFull}, 32'd1);

        // txLoad lands exactly on the frame-start snapshot cycle (third clk after SS falls).
        word   = 1'b0;
        SS     = 1'b0;
        waitClk(2);
        dataTx = 32'h0000_0081;
        txLoad = 1'b1;
        waitClk(1);
        txLoad = 1'b0;
        checkOutput("snap txEmpty", {31'd0, txEmpty}, 32'd0);
        waitClk(2);
        shiftBits(8, 32'h0000_0011, 1'b1, misoVal);
        checkOutput("snap miso now", misoVal, 32'h0000_00FF);
        applyStimulus(1'b0, 32'h0000_0022, misoVal);
        checkOutput("snap miso next", misoVal, 32'h0000_0081);
        checkOutput("snap txEmpty after", {31'd0, txEmpty}, 32'd1);

        // Randomized frames against a holding-register / receive-register model.
        rst = 1'b1;
        waitClk(2);
        rst = 1'b0;
        waitClk(6);
        holdValid = 1'b0; holdVal = '0; mFull = 1'b0; mOvr = 1'b0; mRx = '0;
        for (int it = 0; it < 12; it++) begin
            rw = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                pulseRead();
                mFull = 1'b0;
                mOvr  = 1'b0;
            end
            if ($urandom_range(0, 1) == 1) begin
                rv = $urandom;
                pulseLoad(rv);
                holdValid = 1'b1;
                holdVal   = rv;
            end
            rv        = $urandom;
            mask      = rw ? 32'hFFFF_FFFF : 32'h0000_00FF;
            expTx     = holdValid ? holdVal : 32'hFFFF_FFFF;
            holdValid = 1'b0;
            applyStimulus(rw, rv, misoVal);
            if (mFull) mOvr = 1'b1;
            mFull = 1'b1;
            mRx   = rv & mask;
            checkOutput($sformatf("rand%0d miso", it), misoVal & mask, expTx & mask);
            checkOutput($sformatf("rand%0d dataRx", it), dataRx, mRx);
            checkOutput($sformatf("rand%0d rxFull", it), {31'd0, rxFull}, {31'd0, mFull});
            checkOutput($sformatf("rand%0d ovr", it), {31'd0, ovr}, {31'd0, mOvr});
            checkOutput($sformatf("rand%0d txEmpty", it), {31'd0, txEmpty}, {31'd0, ~holdValid});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
